// File: rtl/popcount_pattern_gen.sv
// Purpose: emits every WIDTH-bit word with popcount k, ascending, as a valid/ready stream.
// Latency: first beat valid one cycle after an accepted start; one beat per cycle after that.
// Backpressure: beat held stable while out_ready is low; abort cancels the stream at once.
module popcount_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5,
    parameter int IDX_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] k,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // One extra bit so the carry out of x + c survives into the Gosper step.
    localparam int XW   = WIDTH + 1;
    localparam int SH_W = $clog2(XW);
    localparam logic [WIDTH-1:0] ONES = '1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_k;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [IDX_W-1:0] r_idx;
    logic             r_last;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    // Start-side values: first pattern is the k lowest bits set, final is the k highest.
    logic [XW-1:0]    w_first_full;
    logic [WIDTH-1:0] w_first;
    logic [WIDTH-1:0] w_top_in;
    logic             w_first_last;
    logic             w_k_bad;

    assign w_first_full = (XW'(1) << k) - XW'(1);
    assign w_first      = w_first_full[WIDTH-1:0];
    assign w_top_in     = ~(ONES >> k);
    assign w_first_last = (w_first == w_top_in);
    assign w_k_bad      = (k > CNT_W'(WIDTH));

    // Gosper's next-same-popcount step on the current pattern.
    logic [XW-1:0]    w_x;
    logic [XW-1:0]    w_c;
    logic [XW-1:0]    w_r;
    logic [XW-1:0]    w_nx_full;
    logic [SH_W-1:0]  w_ctz;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_top;
    logic             w_next_last;
    logic             w_hs;

    assign w_x = {1'b0, r_data};
    // Isolate the lowest set bit: x & -x.
    assign w_c = w_x & (~w_x + XW'(1));
    assign w_r = w_x + w_c;

    // Priority encoder giving the bit position of the one-hot lowest set bit; replaces a divide by c.
    always_comb begin
        w_ctz = '0;
        for (int i = XW - 1; i >= 0; i--) begin
            if (w_c[i]) begin
                w_ctz = SH_W'(i);
            end
        end
    end

    assign w_nx_full   = (((w_r ^ w_x) >> 2) >> w_ctz) | w_r;
    assign w_next      = w_nx_full[WIDTH-1:0];
    assign w_top       = ~(ONES >> r_k);
    assign w_next_last = (w_next == w_top);
    assign w_hs        = r_valid & out_ready;

    // Carry bits above WIDTH are intentionally discarded by truncation.
    logic w_unused;
    assign w_unused = &{1'b0, w_nx_full[WIDTH], w_first_full[WIDTH]};

    // Control FSM with all outputs registered; abort outranks both start and handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        if (w_k_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_k     <= k;
                            r_data  <= w_first;
                            r_idx   <= '0;
                            r_last  <= w_first_last;
                            r_valid <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= ST_EMIT;
                        end
                    end
                end
                ST_EMIT: begin
                    if (abort) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_hs) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_data <= w_next;
                            r_idx  <= r_idx + IDX_W'(1);
                            r_last <= w_next_last;
                        end
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_idx   = r_idx;
    assign out_last  = r_last;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_popcount_pattern_gen.sv
// Randomized bench for popcount_pattern_gen against a brute-force enumeration model.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Model: scan all 2^W words, keep those whose popcount is k, in ascending order.
module tb_popcount_pattern_gen;

    localparam int W  = 8;
    localparam int CW = 5;
    localparam int IW = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] k;
    logic          abort;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;

    popcount_pattern_gen #(
        .WIDTH(W),
        .CNT_W(CW),
        .IDX_W(IW)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .k        (k),
        .abort    (abort),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_idx  (out_idx),
        .out_last (out_last),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one enumeration for popcount kk. Leaves the bench in the cycle right after
    // the stream ends (done cycle, or the cycle after abort) so a caller may start again there.
    task automatic run_k(input int kk, input bit rnd, input int abort_idx, input bit noise);
        int   exp_q[$];
        int   n;
        int   n_exp;
        bit   fin;
        bit   stalled;
        bit   last_hs;
        logic [W-1:0]  held_d;
        logic [IW-1:0] held_i;
        logic          held_l;

        exp_q = {};
        for (int v = 0; v < (1 << W); v++) begin
            if ($countones(v) == kk) exp_q.push_back(v);
        end
        n_exp = exp_q.size();

        start = 1'b1;
        k     = CW'(kk);
        tick();
        start = 1'b0;
        chk("valid_after_start", out_valid, 1);
        chk("busy_after_start", busy, 1);

        n = 0; fin = 0; stalled = 0; held_d = '0; held_i = '0; held_l = 1'b0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (noise) begin
                start = ($urandom_range(0, 3) == 0);
                k     = CW'($urandom_range(0, 8));
            end
            chk("valid_hold", out_valid, 1);
            if (stalled) begin
                chk("stall_data", out_data, held_d);
                chk("stall_idx", out_idx, held_i);
                chk("stall_last", out_last, held_l);
            end
            if (abort_idx >= 0 && n == abort_idx) begin
                chk("abort_at_idx", out_idx, abort_idx);
                abort     = 1'b1;
                out_ready = 1'b1;
                tick();
                abort = 1'b0;
                start = 1'b0;
                chk("abort_valid_drop", out_valid, 0);
                chk("abort_busy_drop", busy, 0);
                chk("abort_no_done", done, 0);
                chk("abort_no_err", err, 0);
                fin = 1;
            end else begin
                last_hs = 0;
                if (out_valid && out_ready) begin
                    if (n < n_exp) begin
                        chk("beat_data", out_data, exp_q[n]);
                        chk("beat_idx", out_idx, n);
                        chk("beat_last", out_last, (n == n_exp - 1));
                    end else begin
                        chk("extra_beat", n, n_exp);
                        fin = 1;
                    end
                    last_hs = out_last;
                    n++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held_d  = out_data;
                    held_i  = out_idx;
                    held_l  = out_last;
                end
                tick();
                start = 1'b0;
                if (last_hs) begin
                    chk("done_pulse", done, 1);
                    chk("valid_after_last", out_valid, 0);
                    chk("busy_after_last", busy, 0);
                    fin = 1;
                end else if (!fin) begin
                    chk("no_early_done", done, 0);
                end
            end
        end
        if (!fin) chk("stream_timeout", 0, 1);
        chk("beat_count", n, (abort_idx >= 0) ? abort_idx : n_exp);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        k         = '0;
        abort     = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #3;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // k=2 full-rate, then k=0 and k=8 started in each preceding done cycle
        run_k(2, 0, -1, 0);
        run_k(0, 0, -1, 0);
        run_k(8, 0, -1, 0);
        tick();
        chk("done_one_cycle", done, 0);
        chk("idle_valid", out_valid, 0);

        // k=4 under random backpressure with start noise during EMIT
        run_k(4, 1, -1, 1);
        chk("k4_final_data", out_data, 8'hF0);
        chk("k4_final_idx", out_idx, 69);
        tick();

        // Illegal k values
        for (int t = 0; t < 2; t++) begin
            start = 1'b1;
            k     = (t == 0) ? CW'(9) : CW'($urandom_range(9, 31));
            tick();
            start = 1'b0;
            chk("err_pulse", err, 1);
            chk("err_busy", busy, 0);
            chk("err_valid", out_valid, 0);
            tick();
            chk("err_one_cycle", err, 0);
            chk("err_valid_stays_low", out_valid, 0);
        end

        // abort in IDLE outranks start
        abort = 1'b1;
        start = 1'b1;
        k     = CW'(3);
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("idle_abort_valid", out_valid, 0);
        chk("idle_abort_busy", busy, 0);
        tick();

        // abort at idx 10 of k=3, then k=1
        run_k(3, 0, 10, 0);
        tick();
        chk("abort_still_no_done", done, 0);
        run_k(1, 0, -1, 0);
        tick();

        // asynchronous reset mid-stream
        start = 1'b1;
        k     = CW'(3);
        tick();
        start     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("pre_rst_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_idx", out_idx, 0);
        chk("arst_busy", busy, 0);
        chk("arst_last", out_last, 0);
        chk("arst_done", done, 0);
        tick();
        #3;
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_done", done, 0);
        out_ready = 1'b0;
        run_k(1, 1, -1, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
